sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single SDRAM controller port between the i-cache line-fill engine and the d-cache.
//  Grants one requester at a time and forwards its ren/wen/addr/wdata to the controller.
//  Steers mem_ack/mem_rdata back to the granted requester only.
//  Grant is held for a whole burst, then released with one idle cycle before the next grant.
//  Sits in the sdram_clk domain between both caches and the SDRAM controller.
// PARAMETERS
//  ADDR_W      21    word-address width (8 MB SDRAM = 2^21 words)
//  TIMEOUT     1023  cycles with no mem_ack before a granted access is abandoned
// PORTS
//  sdram_clk     in   1       single clock; all logic is on its rising edge
//  reset         in   1       synchronous, active-high reset
//  ic_ren        in   1       i-cache read request; held until its first ic_ack
//  ic_addr       in   ADDR_W  i-cache line word address (16-word aligned)
//  ic_ack        out  1       mem_ack forwarded while the i-cache is granted, else 0
//  ic_rdata      out  32      mem_rdata (pass-through)
//  dc_ren        in   1       d-cache read request
//  dc_wen        in   1       d-cache write request (dc_ren & dc_wen together is illegal)
//  dc_addr       in   ADDR_W  d-cache word address
//  dc_wdata      in   32      write data
//  dc_wmask      in   4       byte enables
//  dc_ack        out  1       mem_ack forwarded while the d-cache is granted, else 0
//  dc_rdata      out  32      mem_rdata (pass-through)
//  mem_ren       out  1       controller read strobe
//  mem_wen       out  1       controller write strobe
//  mem_addr      out  ADDR_W  controller word address
//  mem_wdata     out  32      controller write data
//  mem_wmask     out  4       controller byte enables
//  mem_rdata     in   32      controller read data
//  mem_ack       in   1       high for each consecutive data beat of an access
//  arb_timeout   out  1       one-cycle pulse when an access is abandoned
//  busy          out  1       high in every state except IDLE
// BEHAVIOUR
//  - Reset values: state=IDLE, last=DC, ack_seen=0, wdog=0.
//    All mem_* outputs are 0, and ic_ack, dc_ack, arb_timeout and busy are 0.
//  - FSM states: IDLE, GRANT_IC, GRANT_DC, RELEASE.
//  - IDLE:
//    - Requests are sampled every cycle.
//    - A single request is granted.
//    - When both request, the client that is not `last` wins (round-robin), so the first tie after reset goes to the i-cache.
//    - On the grant edge, `last` is updated, and mem_ren/mem_wen/mem_addr/wdata/wmask are registered from the winner.
//    - Grant latency: the request is visible on mem_* one cycle after it is sampled.
//  - GRANT_x:
//    - mem_ren/mem_wen are cleared on the cycle after the first mem_ack; mem_addr/wdata stay stable.
//    - ack_seen is set on the first mem_ack.
//    - The state moves to RELEASE when ack_seen=1 and mem_ack=0 (burst ended).
//  - Ack/data steering is combinational:
//    - ic_ack = mem_ack & (state==GRANT_IC); dc_ack is the same for GRANT_DC.
//    - rdata is passed through to both clients.
//  - mem_ack is ignored in IDLE and RELEASE (never forwarded).
//  - RELEASE:
//    - Lasts one cycle with all mem_* strobes 0.
//    - Clears ack_seen, then returns to IDLE.
//  - Watchdog (wdog):
//    - Counts cycles in GRANT_x while ack_seen=0.
//    - When it reaches TIMEOUT: pulse arb_timeout, drop strobes, go to RELEASE.
//    - The requester gets no ack.
//    - wdog clears on any ack or on leaving GRANT_x, and saturates (never wraps).
//  - A requester that drops its request before the first ack does not cancel the access: the grant runs to completion.
//  - A new request from the granted client during RELEASE waits for IDLE, and is subject to round-robin again.
//  - Reset mid-burst: on the next edge the block is in IDLE with strobes low. Any remaining mem_ack beats are not forwarded.
// STRUCTURE
//  - Package sdram_arb_pkg holds:
//    - typedef enum logic[1:0] arb_state_t {IDLE, GRANT_IC, GRANT_DC, RELEASE};
//    - typedef enum logic client_t {IC, DC};
//    - localparam LINE_WORDS = 16.
//  - One sub-module, sdram_arb_wdog: a saturating counter with clear/enable inputs and an `expired` output.
//  - The FSM, round-robin pick and mux stay in the top module.
// TESTING
//  1. ic_ren alone, addr 0x00100, 16-beat ack -> mem_ren=1 one cycle later; ic_ack high for 16 beats; dc_ack=0; RELEASE one cycle.
//  2. ic_ren and dc_ren rise together after reset -> IC granted first, then DC granted after RELEASE; next tie goes to IC again.
//  3. dc_wen, addr 0x1FFFFF, wdata 0xDEADBEEF, wmask 4'b0101, single ack -> mem_* match exactly; dc_ack is 1 for one cycle.
//  4. No mem_ack for TIMEOUT cycles -> arb_timeout pulses once; strobes drop; a later ack is not forwarded; IDLE after RELEASE.
//  5. reset asserted at beat 5 of an IC burst -> next edge has mem_ren=0 and busy=0; ic_ack=0 for remaining beats.
//  6. DC requests continuously while IC requests -> grants alternate IC/DC; neither client waits more than one burst.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
// Holds the arbiter FSM state encoding, the client identifiers used for
// round-robin tracking, and the i-cache line length in words.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IC = 2'd1,
    GRANT_DC = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } client_t;

  // Words in one i-cache line fill burst.
  localparam int LINE_WORDS = 16;

endpackage : sdram_arb_pkg

// File: rtl/sdram_arb_wdog.sv
// Saturating watchdog counter for the SDRAM port arbiter.
// Counts enabled cycles, clears on request, and flags when the count has
// reached LIMIT. It holds at LIMIT instead of wrapping, so a stuck grant
// can never be forgotten by the counter rolling over.
module sdram_arb_wdog #(
  parameter int LIMIT = 1023,
  localparam int W    = $clog2(LIMIT + 1)
) (
  input  logic sdram_clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] count_r;

  // Cycle counter: clear has priority over counting, and the count saturates at LIMIT.
  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != LIMIT[W-1:0])) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT[W-1:0]);

endmodule : sdram_arb_wdog

// File: rtl/sdram_port_arbiter.sv
// Two-client arbiter in front of the single SDRAM controller port.
// The i-cache line-fill engine and the d-cache compete for the port; a
// round-robin pick resolves ties, the winner owns the port for its whole
// burst, and one RELEASE cycle separates consecutive grants. Acks are
// steered combinationally to the granted client only; read data is
// broadcast. A watchdog abandons grants that never see an ack.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W  = 21,
  parameter int TIMEOUT = 1023
) (
  input  logic              sdram_clk,
  input  logic              reset,
  // i-cache line-fill client
  input  logic              ic_ren,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [31:0]       ic_rdata,
  // d-cache client
  input  logic              dc_ren,
  input  logic              dc_wen,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [31:0]       dc_wdata,
  input  logic [3:0]        dc_wmask,
  output logic              dc_ack,
  output logic [31:0]       dc_rdata,
  // SDRAM controller side
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  // status
  output logic              arb_timeout,
  output logic              busy
);

  arb_state_t        state_r;
  client_t           last_r;
  logic              ack_seen_r;
  logic              mem_ren_r;
  logic              mem_wen_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic [3:0]        mem_wmask_r;
  logic              arb_timeout_r;
  logic              busy_r;

  logic              ic_req_s;
  logic              dc_req_s;
  logic              pick_ic_s;
  logic              granted_s;
  logic              wdog_clr_s;
  logic              wdog_en_s;
  logic              wdog_expired_s;

  assign ic_req_s  = ic_ren;
  assign dc_req_s  = dc_ren | dc_wen;
  assign granted_s = (state_r == GRANT_IC) || (state_r == GRANT_DC);

  // Round-robin pick: on a tie the client that did not win last time goes first.
  always_comb begin
    pick_ic_s = 1'b0;
    if (ic_req_s && dc_req_s) begin
      pick_ic_s = (last_r == DC);
    end else begin
      pick_ic_s = ic_req_s;
    end
  end

  // Watchdog control: count only while granted and still waiting for the first ack.
  always_comb begin
    wdog_clr_s = 1'b1;
    wdog_en_s  = 1'b0;
    if (granted_s) begin
      wdog_clr_s = mem_ack | ack_seen_r;
      wdog_en_s  = ~mem_ack & ~ack_seen_r;
    end else begin
      wdog_clr_s = 1'b1;
      wdog_en_s  = 1'b0;
    end
  end

  sdram_arb_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .sdram_clk (sdram_clk),
    .reset     (reset),
    .clr       (wdog_clr_s),
    .en        (wdog_en_s),
    .expired   (wdog_expired_s)
  );

  // Arbiter FSM with registered controller strobes, address/data, timeout pulse and busy.
  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      state_r       <= IDLE;
      last_r        <= DC;
      ack_seen_r    <= 1'b0;
      mem_ren_r     <= 1'b0;
      mem_wen_r     <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= 32'h0000_0000;
      mem_wmask_r   <= 4'h0;
      arb_timeout_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      arb_timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ic_req_s || dc_req_s) begin
            busy_r <= 1'b1;
            if (pick_ic_s) begin
              state_r     <= GRANT_IC;
              last_r      <= IC;
              mem_ren_r   <= 1'b1;
              mem_wen_r   <= 1'b0;
              mem_addr_r  <= ic_addr;
              mem_wdata_r <= 32'h0000_0000;
              mem_wmask_r <= 4'h0;
            end else begin
              state_r     <= GRANT_DC;
              last_r      <= DC;
              mem_ren_r   <= dc_ren;
              mem_wen_r   <= dc_wen;
              mem_addr_r  <= dc_addr;
              mem_wdata_r <= dc_wdata;
              mem_wmask_r <= dc_wmask;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        GRANT_IC, GRANT_DC: begin
          if (mem_ack) begin
            ack_seen_r <= 1'b1;
            mem_ren_r  <= 1'b0;
            mem_wen_r  <= 1'b0;
          end else if (ack_seen_r) begin
            state_r <= RELEASE;
          end else if (wdog_expired_s) begin
            state_r       <= RELEASE;
            arb_timeout_r <= 1'b1;
            mem_ren_r     <= 1'b0;
            mem_wen_r     <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end
        RELEASE: begin
          state_r    <= IDLE;
          ack_seen_r <= 1'b0;
          mem_ren_r  <= 1'b0;
          mem_wen_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          ack_seen_r <= 1'b0;
          mem_ren_r  <= 1'b0;
          mem_wen_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign mem_ren     = mem_ren_r;
  assign mem_wen     = mem_wen_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign mem_wmask   = mem_wmask_r;
  assign arb_timeout = arb_timeout_r;
  assign busy        = busy_r;

  // Acks reach only the granted client; IDLE and RELEASE swallow stray beats.
  assign ic_ack   = mem_ack & (state_r == GRANT_IC);
  assign dc_ack   = mem_ack & (state_r == GRANT_DC);
  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;

endmodule : sdram_port_arbiter

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter.
// Drives requests and controller acks, checks every expectation with an
// immediate assertion, and prints a single summary line.
module tb_sdram_port_arbiter;

  localparam int ADDR_W  = 21;
  localparam int TIMEOUT = 1023;

  logic              sdram_clk = 1'b0;
  logic              reset     = 1'b1;
  logic              ic_ren    = 1'b0;
  logic [ADDR_W-1:0] ic_addr   = '0;
  logic              ic_ack;
  logic [31:0]       ic_rdata;
  logic              dc_ren    = 1'b0;
  logic              dc_wen    = 1'b0;
  logic [ADDR_W-1:0] dc_addr   = '0;
  logic [31:0]       dc_wdata  = 32'h0;
  logic [3:0]        dc_wmask  = 4'h0;
  logic              dc_ack;
  logic [31:0]       dc_rdata;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_rdata = 32'h0;
  logic              mem_ack   = 1'b0;
  logic              arb_timeout;
  logic              busy;

  int tests  = 0;
  int failed = 0;

  sdram_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sdram_clk   (sdram_clk),
    .reset       (reset),
    .ic_ren      (ic_ren),
    .ic_addr     (ic_addr),
    .ic_ack      (ic_ack),
    .ic_rdata    (ic_rdata),
    .dc_ren      (dc_ren),
    .dc_wen      (dc_wen),
    .dc_addr     (dc_addr),
    .dc_wdata    (dc_wdata),
    .dc_wmask    (dc_wmask),
    .dc_ack      (dc_ack),
    .dc_rdata    (dc_rdata),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .arb_timeout (arb_timeout),
    .busy        (busy)
  );

  always #5 sdram_clk = ~sdram_clk;

  task automatic step();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ic_ren   = 1'b0;
    dc_ren   = 1'b0;
    dc_wen   = 1'b0;
    mem_ack  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Runs an n-beat burst for the granted client, then walks RELEASE and IDLE.
  task automatic burst(input int n, input logic to_ic, input logic drop);
    logic [31:0] d;
    for (int b = 0; b < n; b++) begin
      d         = 32'hA500_0000 | 32'(b);
      mem_ack   = 1'b1;
      mem_rdata = d;
      #1;
      check("ic_ack_beat", ic_ack, to_ic);
      check("dc_ack_beat", dc_ack, !to_ic);
      check("rdata_pass", to_ic ? ic_rdata : dc_rdata, d);
      step();
      if (b == 0) begin
        check("strobe_clr", {mem_ren, mem_wen}, 2'b00);
        if (drop) begin
          if (to_ic) ic_ren = 1'b0;
          else begin
            dc_ren = 1'b0;
            dc_wen = 1'b0;
          end
        end
      end
    end
    mem_ack = 1'b0;
    #1;
    check("ack_end", {ic_ack, dc_ack}, 2'b00);
    step();
    check("release_busy", busy, 1'b1);
    check("release_strb", {mem_ren, mem_wen}, 2'b00);
    step();
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_strobes", {mem_ren, mem_wen}, 2'b00);
    check("rst_addr", mem_addr, 21'h0);
    check("rst_wdata", {mem_wdata, mem_wmask}, 36'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_tmo", arb_timeout, 1'b0);
    check("rst_acks", {ic_ack, dc_ack}, 2'b00);

    // 1: lone i-cache line fill
    ic_ren  = 1'b1;
    ic_addr = 21'h00100;
    step();
    check("t1_ren", mem_ren, 1'b1);
    check("t1_wen", mem_wen, 1'b0);
    check("t1_addr", mem_addr, 21'h00100);
    check("t1_busy", busy, 1'b1);
    burst(16, 1'b1, 1'b1);

    // 2: simultaneous requests after reset, IC first then DC, then IC again
    do_reset();
    ic_ren  = 1'b1;
    ic_addr = 21'h00200;
    dc_ren  = 1'b1;
    dc_addr = 21'h00333;
    step();
    check("t2_grant_ic", mem_addr, 21'h00200);
    burst(4, 1'b1, 1'b1);
    step();
    check("t2_grant_dc", mem_addr, 21'h00333);
    check("t2_dc_ren", mem_ren, 1'b1);
    burst(2, 1'b0, 1'b1);
    ic_ren = 1'b1;
    dc_ren = 1'b1;
    step();
    check("t2_tie_ic", mem_addr, 21'h00200);
    ic_ren = 1'b0;
    dc_ren = 1'b0;
    burst(1, 1'b1, 1'b1);

    // 3: d-cache write at top of memory
    do_reset();
    dc_wen   = 1'b1;
    dc_addr  = 21'h1FFFFF;
    dc_wdata = 32'hDEADBEEF;
    dc_wmask = 4'b0101;
    step();
    check("t3_wen", mem_wen, 1'b1);
    check("t3_ren", mem_ren, 1'b0);
    check("t3_addr", mem_addr, 21'h1FFFFF);
    check("t3_wdata", mem_wdata, 32'hDEADBEEF);
    check("t3_wmask", mem_wmask, 4'b0101);
    burst(1, 1'b0, 1'b1);

    // 4: watchdog timeout
    do_reset();
    ic_ren  = 1'b1;
    ic_addr = 21'h00440;
    step();
    ic_ren = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) step();
    check("t4_pre_tmo", arb_timeout, 1'b0);
    check("t4_pre_ren", mem_ren, 1'b1);
    step();
    check("t4_tmo", arb_timeout, 1'b1);
    check("t4_ren_drop", mem_ren, 1'b0);
    check("t4_rel_busy", busy, 1'b1);
    mem_ack = 1'b1;
    #1;
    check("t4_late_ack", ic_ack, 1'b0);
    step();
    check("t4_tmo_once", arb_timeout, 1'b0);
    check("t4_idle", busy, 1'b0);
    check("t4_idle_ack", ic_ack, 1'b0);
    mem_ack = 1'b0;

    // 5: reset at beat 5 of an i-cache burst
    do_reset();
    ic_ren  = 1'b1;
    ic_addr = 21'h00500;
    step();
    for (int b = 0; b < 5; b++) begin
      mem_ack = 1'b1;
      #1;
      check("t5_ack", ic_ack, 1'b1);
      step();
      ic_ren = 1'b0;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_ren", mem_ren, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_addr", mem_addr, 21'h0);
    for (int b = 6; b < 16; b++) begin
      check("t5_no_ack", ic_ack, 1'b0);
      step();
    end
    mem_ack = 1'b0;

    // 6: both clients keep requesting, grants alternate
    do_reset();
    ic_ren  = 1'b1;
    ic_addr = 21'h00600;
    dc_ren  = 1'b1;
    dc_addr = 21'h00777;
    for (int g = 0; g < 4; g++) begin
      step();
      check("t6_grant", mem_addr, (g % 2 == 0) ? 21'h00600 : 21'h00777);
      burst(2, (g % 2 == 0), 1'b0);
    end
    ic_ren = 1'b0;
    dc_ren = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_sdram_port_arbiter
